// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use the master side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;

  logic          m_en;
  logic          m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack, i_err,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output m_en, m_we, m_size, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack, i_err,
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  m_en, m_we, m_size, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and load/store.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | arbitrate, check alignment, load the memory command
// S_ISSUE | m_en high for one cycle, latency counter loaded
// S_WAIT  | counting down MEM_LAT; read data captured when count == 1
// S_ACK   | one-cycle ack (with err on the misaligned path)
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          last_d;
  logic          grant_d;
  logic          cur_we;

  logic          pick_i;
  logic          pick_d;
  logic          mis_d;
  logic          win_mis;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    pick_i = bus.i_req && (!bus.d_req || last_d);
    pick_d = bus.d_req && !pick_i;
    case (bus.d_size)
      2'd0:    mis_d = 1'b0;
      2'd1:    mis_d = bus.d_addr[0];
      2'd2:    mis_d = (bus.d_addr[1:0] != 2'b00);
      default: mis_d = 1'b1;
    endcase
    win_mis   = pick_i ? (bus.i_addr[1:0] != 2'b00) : mis_d;
    win_addr  = pick_d ? bus.d_addr : bus.i_addr;
    win_wdata = pick_d ? bus.d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_d      <= 1'b1;
      grant_d     <= 1'b0;
      cur_we      <= 1'b0;
      bus.i_rdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_size  <= '0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_i || pick_d) begin
            grant_d <= pick_d;
            last_d  <= pick_d;
            if (win_mis) begin
              // Misaligned: never touch memory, acknowledge straight away with err.
              state <= S_ACK;
              if (pick_d) begin
                bus.d_ack <= 1'b1;
                bus.d_err <= 1'b1;
              end else begin
                bus.i_ack <= 1'b1;
                bus.i_err <= 1'b1;
              end
            end else begin
              state       <= S_ISSUE;
              bus.m_en    <= 1'b1;
              bus.m_we    <= pick_d && bus.d_we;
              bus.m_size  <= pick_d ? bus.d_size : 2'd2;
              bus.m_addr  <= win_addr;
              bus.m_wdata <= win_wdata;
              cur_we      <= pick_d && bus.d_we;
            end
          end
        end
        S_ISSUE: begin
          bus.m_en <= 1'b0;
          bus.m_we <= 1'b0;
          cnt      <= 4'(MEM_LAT);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_ACK;
            if (grant_d) begin
              bus.d_ack <= 1'b1;
              bus.d_err <= 1'b0;
              if (!cur_we) bus.d_rdata <= bus.m_rdata;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_err   <= 1'b0;
              bus.i_rdata <= bus.m_rdata;
            end
          end
        end
        S_ACK: begin
          bus.i_ack <= 1'b0;
          bus.i_err <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.d_err <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at MEM_LAT = 1, 3 and 4.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1, rst3, rst4;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus4 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (bus1.m_en !== 1'b0) begin n_err++; $display("FAIL reset_m_en1 got %b exp 0", bus1.m_en); end
    n_cmp++; if (bus1.m_addr !== 32'h0) begin n_err++; $display("FAIL reset_m_addr1 got %h exp 0", bus1.m_addr); end
    n_cmp++; if (bus1.m_size !== 2'd0) begin n_err++; $display("FAIL reset_m_size1 got %h exp 0", bus1.m_size); end
    n_cmp++; if (bus1.i_ack !== 1'b0) begin n_err++; $display("FAIL reset_i_ack1 got %b exp 0", bus1.i_ack); end
    n_cmp++; if (bus1.d_ack !== 1'b0) begin n_err++; $display("FAIL reset_d_ack1 got %b exp 0", bus1.d_ack); end
    n_cmp++; if (bus1.i_rdata !== 32'h0) begin n_err++; $display("FAIL reset_i_rdata1 got %h exp 0", bus1.i_rdata); end
    n_cmp++; if (bus1.d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata1 got %h exp 0", bus1.d_rdata); end
    n_cmp++; if (bus3.m_en !== 1'b0) begin n_err++; $display("FAIL reset_m_en3 got %b exp 0", bus3.m_en); end
    n_cmp++; if (bus4.m_we !== 1'b0) begin n_err++; $display("FAIL reset_m_we4 got %b exp 0", bus4.m_we); end
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
  endtask

  task automatic test_fetch();
    bus1.i_req = 1'b1; bus1.i_addr = 32'h0000_0040;
    for (int c = 0; c <= 4; c++) begin
      bus1.m_rdata = (c == 2) ? 32'h0000_0013 : 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++; if (bus1.m_en !== (c == 1)) begin n_err++; $display("FAIL fetch_m_en c=%0d got %b exp %b", c, bus1.m_en, (c == 1)); end
      n_cmp++; if (bus1.i_ack !== (c == 3)) begin n_err++; $display("FAIL fetch_i_ack c=%0d got %b exp %b", c, bus1.i_ack, (c == 3)); end
      n_cmp++; if (bus1.d_ack !== 1'b0) begin n_err++; $display("FAIL fetch_d_ack c=%0d got %b exp 0", c, bus1.d_ack); end
      if (c == 1) begin
        n_cmp++; if (bus1.m_addr !== 32'h40) begin n_err++; $display("FAIL fetch_m_addr got %h exp 40", bus1.m_addr); end
        n_cmp++; if (bus1.m_size !== 2'd2) begin n_err++; $display("FAIL fetch_m_size got %0d exp 2", bus1.m_size); end
        n_cmp++; if (bus1.m_we !== 1'b0) begin n_err++; $display("FAIL fetch_m_we got %b exp 0", bus1.m_we); end
      end
      if (c == 3) begin
        n_cmp++; if (bus1.i_rdata !== 32'h13) begin n_err++; $display("FAIL fetch_i_rdata got %h exp 13", bus1.i_rdata); end
        n_cmp++; if (bus1.i_err !== 1'b0) begin n_err++; $display("FAIL fetch_i_err got %b exp 0", bus1.i_err); end
      end
      @(posedge clk); #1;
      if (c == 3) bus1.i_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h0000_0080;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_size = 2'd2; bus1.d_addr = 32'h0000_0100;
    for (int c = 0; c <= 8; c++) begin
      bus1.m_rdata = (c == 2) ? 32'h1111_1111 : (c == 6) ? 32'h2222_2222 : 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++; if (bus1.m_en !== (c == 1 || c == 5)) begin n_err++; $display("FAIL b2b_m_en c=%0d got %b exp %b", c, bus1.m_en, (c == 1 || c == 5)); end
      n_cmp++; if (bus1.i_ack !== (c == 3)) begin n_err++; $display("FAIL b2b_i_ack c=%0d got %b exp %b", c, bus1.i_ack, (c == 3)); end
      n_cmp++; if (bus1.d_ack !== (c == 7)) begin n_err++; $display("FAIL b2b_d_ack c=%0d got %b exp %b", c, bus1.d_ack, (c == 7)); end
      if (c == 1) begin
        n_cmp++; if (bus1.m_addr !== 32'h80) begin n_err++; $display("FAIL b2b_first_addr got %h exp 80", bus1.m_addr); end
      end
      if (c == 3) begin
        n_cmp++; if (bus1.i_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_i_rdata got %h exp 11111111", bus1.i_rdata); end
      end
      if (c == 5) begin
        n_cmp++; if (bus1.m_addr !== 32'h100) begin n_err++; $display("FAIL b2b_second_addr got %h exp 100", bus1.m_addr); end
        n_cmp++; if (bus1.m_size !== 2'd2) begin n_err++; $display("FAIL b2b_m_size got %0d exp 2", bus1.m_size); end
      end
      if (c == 7) begin
        n_cmp++; if (bus1.d_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_d_rdata got %h exp 22222222", bus1.d_rdata); end
        n_cmp++; if (bus1.d_err !== 1'b0) begin n_err++; $display("FAIL b2b_d_err got %b exp 0", bus1.d_err); end
      end
      @(posedge clk); #1;
      if (c == 3) bus1.i_req = 1'b0;
      if (c == 7) bus1.d_req = 1'b0;
    end
  endtask

  task automatic test_misaligned();
    bus1.m_rdata = 32'hDEAD_BEEF;
    for (int v = 0; v < 3; v++) begin
      if (v == 2) begin
        bus1.i_req = 1'b1; bus1.i_addr = 32'h0000_0042;
      end else begin
        bus1.d_req = 1'b1; bus1.d_we = 1'b0;
        bus1.d_size = (v == 0) ? 2'd2 : 2'd3;
        bus1.d_addr = (v == 0) ? 32'h0000_0102 : 32'h0000_0100;
      end
      for (int c = 0; c <= 2; c++) begin
        @(negedge clk);
        n_cmp++; if (bus1.m_en !== 1'b0) begin n_err++; $display("FAIL mis_m_en v=%0d c=%0d got %b exp 0", v, c, bus1.m_en); end
        n_cmp++; if (bus1.i_ack !== (v == 2 && c == 1)) begin n_err++; $display("FAIL mis_i_ack v=%0d c=%0d got %b exp %b", v, c, bus1.i_ack, (v == 2 && c == 1)); end
        n_cmp++; if (bus1.d_ack !== (v != 2 && c == 1)) begin n_err++; $display("FAIL mis_d_ack v=%0d c=%0d got %b exp %b", v, c, bus1.d_ack, (v != 2 && c == 1)); end
        if (c == 1 && v == 2) begin
          n_cmp++; if (bus1.i_err !== 1'b1) begin n_err++; $display("FAIL mis_i_err got %b exp 1", bus1.i_err); end
          n_cmp++; if (bus1.i_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL mis_i_rdata got %h exp 11111111", bus1.i_rdata); end
        end
        if (c == 1 && v != 2) begin
          n_cmp++; if (bus1.d_err !== 1'b1) begin n_err++; $display("FAIL mis_d_err v=%0d got %b exp 1", v, bus1.d_err); end
          n_cmp++; if (bus1.d_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL mis_d_rdata v=%0d got %h exp 22222222", v, bus1.d_rdata); end
        end
        @(posedge clk); #1;
        if (c == 1) begin bus1.i_req = 1'b0; bus1.d_req = 1'b0; end
      end
    end
  endtask

  task automatic test_store();
    bus3.m_rdata = 32'hCAFE_F00D;
    bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_size = 2'd0;
    bus3.d_addr = 32'h0000_0203; bus3.d_wdata = 32'h0000_00AB;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (bus3.m_en !== (c == 1)) begin n_err++; $display("FAIL st_m_en c=%0d got %b exp %b", c, bus3.m_en, (c == 1)); end
      n_cmp++; if (bus3.m_we !== (c == 1)) begin n_err++; $display("FAIL st_m_we c=%0d got %b exp %b", c, bus3.m_we, (c == 1)); end
      n_cmp++; if (bus3.d_ack !== (c == 5)) begin n_err++; $display("FAIL st_d_ack c=%0d got %b exp %b", c, bus3.d_ack, (c == 5)); end
      if (c == 1) begin
        n_cmp++; if (bus3.m_addr !== 32'h203) begin n_err++; $display("FAIL st_m_addr got %h exp 203", bus3.m_addr); end
        n_cmp++; if (bus3.m_size !== 2'd0) begin n_err++; $display("FAIL st_m_size got %0d exp 0", bus3.m_size); end
        n_cmp++; if (bus3.m_wdata !== 32'hAB) begin n_err++; $display("FAIL st_m_wdata got %h exp ab", bus3.m_wdata); end
      end
      if (c == 3) begin
        n_cmp++; if (bus3.m_addr !== 32'h203) begin n_err++; $display("FAIL st_addr_hold got %h exp 203", bus3.m_addr); end
      end
      if (c == 5) begin
        n_cmp++; if (bus3.d_err !== 1'b0) begin n_err++; $display("FAIL st_d_err got %b exp 0", bus3.d_err); end
        n_cmp++; if (bus3.d_rdata !== 32'h0) begin n_err++; $display("FAIL st_d_rdata got %h exp 0", bus3.d_rdata); end
      end
      @(posedge clk); #1;
      if (c == 5) bus3.d_req = 1'b0;
    end
  endtask

  task automatic test_reset_wait();
    bus4.i_req = 1'b1; bus4.i_addr = 32'h0000_0300;
    for (int c = 0; c <= 9; c++) begin
      bus4.m_rdata = (c == 5) ? 32'h7777_7777 : 32'hDEAD_BEEF;
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus4.m_en !== 1'b1) begin n_err++; $display("FAIL rw_m_en got %b exp 1", bus4.m_en); end
        n_cmp++; if (bus4.m_addr !== 32'h300) begin n_err++; $display("FAIL rw_m_addr got %h exp 300", bus4.m_addr); end
      end
      n_cmp++; if (bus4.i_ack !== 1'b0) begin n_err++; $display("FAIL rw_no_ack c=%0d got %b exp 0", c, bus4.i_ack); end
      if (c >= 4) begin
        n_cmp++; if (bus4.m_addr !== 32'h0) begin n_err++; $display("FAIL rw_addr_clr c=%0d got %h exp 0", c, bus4.m_addr); end
        n_cmp++; if (bus4.i_rdata !== 32'h0) begin n_err++; $display("FAIL rw_rdata_clr c=%0d got %h exp 0", c, bus4.i_rdata); end
        n_cmp++; if (bus4.m_en !== 1'b0) begin n_err++; $display("FAIL rw_m_en_clr c=%0d got %b exp 0", c, bus4.m_en); end
      end
      @(posedge clk); #1;
      if (c == 2) begin rst4 = 1'b1; bus4.i_req = 1'b0; end
      if (c == 3) rst4 = 1'b0;
    end
    bus4.i_req = 1'b1; bus4.i_addr = 32'h0000_0304;
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_size = 2'd2; bus4.d_addr = 32'h0000_0400;
    for (int c = 0; c <= 14; c++) begin
      bus4.m_rdata = (c == 5) ? 32'h0BAD_F00D : (c == 12) ? 32'h600D_CAFE : 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++; if (bus4.m_en !== (c == 1 || c == 8)) begin n_err++; $display("FAIL rw2_m_en c=%0d got %b exp %b", c, bus4.m_en, (c == 1 || c == 8)); end
      n_cmp++; if (bus4.i_ack !== (c == 6)) begin n_err++; $display("FAIL rw2_i_ack c=%0d got %b exp %b", c, bus4.i_ack, (c == 6)); end
      n_cmp++; if (bus4.d_ack !== (c == 13)) begin n_err++; $display("FAIL rw2_d_ack c=%0d got %b exp %b", c, bus4.d_ack, (c == 13)); end
      if (c == 1) begin
        n_cmp++; if (bus4.m_addr !== 32'h304) begin n_err++; $display("FAIL rw2_tie_addr got %h exp 304", bus4.m_addr); end
      end
      if (c == 6) begin
        n_cmp++; if (bus4.i_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rw2_i_rdata got %h exp 0badf00d", bus4.i_rdata); end
      end
      if (c == 8) begin
        n_cmp++; if (bus4.m_addr !== 32'h400) begin n_err++; $display("FAIL rw2_d_addr got %h exp 400", bus4.m_addr); end
      end
      if (c == 13) begin
        n_cmp++; if (bus4.d_rdata !== 32'h600D_CAFE) begin n_err++; $display("FAIL rw2_d_rdata got %h exp 600dcafe", bus4.d_rdata); end
      end
      @(posedge clk); #1;
      if (c == 6) bus4.i_req = 1'b0;
      if (c == 13) bus4.d_req = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_size = '0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.m_rdata = 32'hDEAD_BEEF;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_size = '0; bus3.d_addr = '0; bus3.d_wdata = '0; bus3.m_rdata = 32'hDEAD_BEEF;
    bus4.i_req = 1'b0; bus4.i_addr = '0; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
    bus4.d_size = '0; bus4.d_addr = '0; bus4.d_wdata = '0; bus4.m_rdata = 32'hDEAD_BEEF;

    test_reset();
    test_fetch();
    test_back_to_back();
    test_misaligned();
    test_store();
    test_reset_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
